// File: rtl/mem_responder.sv
// Word-addressed backing store answering the cache's memory-side requests after a fixed latency.
// Optional feature macro MEM_RESPONDER_STATS_EN adds saturating read/write completion counters.
module mem_responder #(
    parameter int unsigned ADDR_WIDTH    = 64,
    parameter int unsigned WORD_WIDTH    = 64,
    parameter int unsigned SIZE_BITS     = 10,
    parameter int unsigned READ_LATENCY  = 4,
    parameter int unsigned WRITE_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WORD_WIDTH-1:0] din,
    output logic [WORD_WIDTH-1:0] dout,
    input  logic                  re,
    input  logic                  we,
    output logic                  ready
`ifdef MEM_RESPONDER_STATS_EN
    ,
    output logic [31:0]           read_count,
    output logic [31:0]           write_count
`endif
);

    localparam int unsigned DEPTH = 2 ** SIZE_BITS;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE
    } state_e;

    state_e                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [SIZE_BITS-1:0]   a_q, a_d;
    logic [WORD_WIDTH-1:0]  d_q, d_d;
    logic [WORD_WIDTH-1:0]  dout_q, dout_d;
    logic                   mem_we;

    logic [WORD_WIDTH-1:0]  mem [DEPTH] = '{default: '0};

    // Upper address bits are deliberately ignored: addresses wrap modulo DEPTH.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[ADDR_WIDTH-1:SIZE_BITS];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        d_d     = d_q;
        dout_d  = dout_q;
        mem_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (we) begin
                    state_d = WRITE;
                    cnt_d   = 8'(WRITE_LATENCY - 1);
                    a_d     = addr[SIZE_BITS-1:0];
                    d_d     = din;
                end else if (re) begin
                    state_d = READ;
                    cnt_d   = 8'(READ_LATENCY - 1);
                    a_d     = addr[SIZE_BITS-1:0];
                end
            end
            READ: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    dout_d  = mem[a_q];
                    state_d = IDLE;
                end
            end
            WRITE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    mem_we  = ~rst;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
        end
    end

    // Index/data latches and storage are left untouched by reset.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        d_q <= d_d;
        if (mem_we) begin
            mem[a_q] <= d_q;
        end
    end

    assign dout  = dout_q;
    assign ready = (state_q == IDLE);

`ifdef MEM_RESPONDER_STATS_EN
    logic [31:0] read_count_q, read_count_d;
    logic [31:0] write_count_q, write_count_d;

    always_comb begin
        read_count_d  = read_count_q;
        write_count_d = write_count_q;
        if (state_q == READ && cnt_q == '0 && read_count_q != '1) begin
            read_count_d = read_count_q + 32'd1;
        end
        if (state_q == WRITE && cnt_q == '0 && write_count_q != '1) begin
            write_count_d = write_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            read_count_q  <= '0;
            write_count_q <= '0;
        end else begin
            read_count_q  <= read_count_d;
            write_count_q <= write_count_d;
        end
    end

    assign read_count  = read_count_q;
    assign write_count = write_count_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed plan steps plus randomized traffic
// compared cycle by cycle against a transaction-level reference model.
module tb_mem_responder;

    localparam int unsigned AW = 64;
    localparam int unsigned WW = 64;
    localparam int unsigned SB = 10;
    localparam int unsigned RL = 4;
    localparam int unsigned WL = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          re = 1'b0;
    logic          we = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [WW-1:0] din = '0;
    logic [WW-1:0] dout;
    logic          ready;
`ifdef MEM_RESPONDER_STATS_EN
    logic [31:0]   read_count;
    logic [31:0]   write_count;
`endif

    mem_responder #(
        .ADDR_WIDTH   (AW),
        .WORD_WIDTH   (WW),
        .SIZE_BITS    (SB),
        .READ_LATENCY (RL),
        .WRITE_LATENCY(WL)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .addr (addr),
        .din  (din),
        .dout (dout),
        .re   (re),
        .we   (we),
        .ready(ready)
`ifdef MEM_RESPONDER_STATS_EN
        ,
        .read_count (read_count),
        .write_count(write_count)
`endif
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: remaining busy cycles plus the one outstanding transaction.
    logic [WW-1:0] m_mem [2**SB];
    int            m_busy = 0;
    bit            m_is_wr = 1'b0;
    int unsigned   m_idx = 0;
    logic [WW-1:0] m_data = '0;
    logic [WW-1:0] m_dout = '0;
    int unsigned   m_rc = 0;
    int unsigned   m_wc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit w, input bit r, input bit rs,
                              input logic [AW-1:0] a, input logic [WW-1:0] d);
        if (rs) begin
            m_busy = 0;
            m_dout = '0;
            m_rc   = 0;
            m_wc   = 0;
        end else if (m_busy == 0) begin
            if (w) begin
                m_busy  = WL;
                m_is_wr = 1'b1;
                m_idx   = 32'(a % 64'(2 ** SB));
                m_data  = d;
            end else if (r) begin
                m_busy  = RL;
                m_is_wr = 1'b0;
                m_idx   = 32'(a % 64'(2 ** SB));
            end
        end else begin
            m_busy--;
            if (m_busy == 0) begin
                if (m_is_wr) begin
                    m_mem[m_idx] = m_data;
                    m_wc++;
                end else begin
                    m_dout = m_mem[m_idx];
                    m_rc++;
                end
            end
        end
    endtask

    task automatic cyc(input bit w, input bit r, input bit rs,
                       input logic [AW-1:0] a, input logic [WW-1:0] d, input string tag);
        @(negedge clk);
        we   = w;
        re   = r;
        rst  = rs;
        addr = a;
        din  = d;
        @(posedge clk);
        model_step(w, r, rs, a, d);
        #1;
        chk({tag, "/ready"}, 64'(ready), 64'(m_busy == 0));
        chk({tag, "/dout"}, dout, m_dout);
`ifdef MEM_RESPONDER_STATS_EN
        chk({tag, "/read_count"}, 64'(read_count), 64'(m_rc));
        chk({tag, "/write_count"}, 64'(write_count), 64'(m_wc));
`endif
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, '0, '0, tag);
    endtask

    initial begin
        int highs;
        logic [AW-1:0] ra;

        foreach (m_mem[i]) m_mem[i] = '0;

        // Reset for two cycles.
        cyc(1'b0, 1'b0, 1'b1, '0, '0, "reset");
        cyc(1'b0, 1'b0, 1'b1, '0, '0, "reset");
        idle(1, "post_reset");
        chk("reset_ready", 64'(ready), 64'd1);
        chk("reset_dout", dout, 64'd0);

        // Write 5, ready low for WL cycles, dout untouched.
        cyc(1'b1, 1'b0, 1'b0, 64'd5, 64'hDEAD_BEEF, "wr5");
        chk("wr5_busy", 64'(ready), 64'd0);
        idle(WL, "wr5_wait");
        chk("wr5_done_ready", 64'(ready), 64'd1);
        chk("wr5_dout_still_0", dout, 64'd0);

        // Read 5 with a write strobe during the busy period that must be ignored.
        cyc(1'b0, 1'b1, 1'b0, 64'd5, '0, "rd5");
        idle(1, "rd5_wait");
        cyc(1'b1, 1'b0, 1'b0, 64'd5, 64'h22, "busy_we");
        idle(2, "rd5_wait");
        chk("rd5_ready", 64'(ready), 64'd1);
        chk("rd5_data", dout, 64'hDEAD_BEEF);
        cyc(1'b0, 1'b1, 1'b0, 64'd5, '0, "rd5_again");
        idle(RL, "rd5_again_wait");
        chk("busy_ignore_data", dout, 64'hDEAD_BEEF);

        // Address wrap.
        cyc(1'b1, 1'b0, 1'b0, 64'(2 ** SB) + 64'd3, 64'h11, "wrap_wr");
        idle(WL, "wrap_wr_wait");
        cyc(1'b0, 1'b1, 1'b0, 64'd3, '0, "wrap_rd");
        idle(RL, "wrap_rd_wait");
        chk("wrap_data", dout, 64'h11);

        // re and we held together: write wins, back-to-back with one ready-high gap.
        highs = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 64'd7, 64'h33, "held");
            if (i < 9 && ready === 1'b1) highs++;
        end
        chk("held_ready_gap", 64'(highs), 64'd1);
        chk("held_ready_end", 64'(ready), 64'd1);
        chk("held_dout_kept", dout, 64'h11);
        cyc(1'b0, 1'b1, 1'b0, 64'd7, '0, "held_rd");
        idle(RL, "held_rd_wait");
        chk("held_data", dout, 64'h33);

        // Reset in the middle of a write drops it.
        cyc(1'b1, 1'b0, 1'b0, 64'd9, 64'h44, "abort_wr");
        idle(1, "abort_wait");
        cyc(1'b0, 1'b0, 1'b1, '0, '0, "abort_rst");
        chk("abort_ready", 64'(ready), 64'd1);
`ifdef MEM_RESPONDER_STATS_EN
        chk("abort_write_count", 64'(write_count), 64'd0);
`endif
        cyc(1'b0, 1'b1, 1'b0, 64'd9, '0, "abort_rd");
        idle(RL, "abort_rd_wait");
        chk("abort_data", dout, 64'd0);
        chk("storage_kept", 64'(m_mem[5]), 64'hDEAD_BEEF);

        // Randomized traffic over a small index window with random upper address bits.
        for (int i = 0; i < 800; i++) begin
            ra = {$urandom, $urandom};
            ra[SB-1:0] = SB'($urandom_range(0, 15));
            cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 63) == 0), ra, {$urandom, $urandom}, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
